// File: rtl/imem_load_arbiter.sv
// Arbitrates the byte-wide instruction memory port between CPU fetch and a word loader.
// Each loaded word is written as BYTE_SIZE little-endian byte writes. Fetch is guaranteed a slot after each word.
module imem_load_arbiter #(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    f_req_i,
  input  logic [ADDR_WIDTH-1:0]   f_addr_i,
  output logic [BYTE_SIZE*8-1:0]  f_rdata_o,
  output logic                    f_valid_o,
  output logic                    f_stall_o,
  input  logic                    l_valid_i,
  input  logic [ADDR_WIDTH-1:0]   l_addr_i,
  input  logic [BYTE_SIZE*8-1:0]  l_wdata_i,
  output logic                    l_ready_o,
  output logic                    l_done_o,
  output logic [CNT_WIDTH-1:0]    word_cnt_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic                    m_we_o,
  output logic [7:0]              m_wdata_o,
  input  logic [BYTE_SIZE*8-1:0]  m_rd_i
);

  localparam int WORD_W = BYTE_SIZE * 8;
  localparam int IDX_W  = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   credit_q;
  logic                   seen_q;
  logic                   l_done_q;
  logic                   m_we_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic [CNT_WIDTH-1:0]   cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [WORD_W-1:0]      wdata_q;
  logic                   idle;
  logic                   l_ready;
  logic                   accept;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign idle    = (state_q == S_IDLE);
  // A pending fetch owed a slot from the previous word blocks the loader for one cycle.
  assign l_ready = idle && !(credit_q && f_req_i);
  assign accept  = l_valid_i && l_ready;
  assign cnt_d   = sat_inc(cnt_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      credit_q <= 1'b0;
      seen_q   <= 1'b0;
      l_done_q <= 1'b0;
      m_we_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          credit_q <= 1'b0;
          if (accept) begin
            state_q <= S_WRITE;
            idx_q   <= '0;
            seen_q  <= 1'b0;
            m_we_q  <= 1'b1;
          end
        end
        S_WRITE: begin
          seen_q <= seen_q | f_req_i;
          if (idx_q == LAST_IDX) begin
            state_q  <= S_DONE;
            m_we_q   <= 1'b0;
            l_done_q <= 1'b1;
            cnt_q    <= cnt_d;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          l_done_q <= 1'b0;
          credit_q <= seen_q | f_req_i;
        end
        default: begin
          state_q  <= S_IDLE;
          m_we_q   <= 1'b0;
          l_done_q <= 1'b0;
        end
      endcase
    end
  end

  // Word/address capture is pure data; the FSM qualifies its use, so no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= l_addr_i;
      wdata_q <= l_wdata_i;
    end
  end

  assign m_we_o     = m_we_q;
  assign m_addr_o   = (state_q == S_WRITE) ? addr_q + ADDR_WIDTH'(idx_q) : f_addr_i;
  assign m_wdata_o  = wdata_q[8*idx_q +: 8];
  assign f_rdata_o  = m_rd_i;
  assign f_valid_o  = idle && f_req_i;
  assign f_stall_o  = !idle && f_req_i;
  assign l_ready_o  = l_ready;
  assign l_done_o   = l_done_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: vector table plus contention, wrap, reset and saturation sequences.
module tb_imem_load_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req;
  logic [31:0] f_addr;
  logic        l_valid;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] f_rdata, f_rdata2;
  logic        f_valid, f_stall, f_valid2, f_stall2;
  logic        l_ready, l_done, l_ready2, l_done2;
  logic [15:0] word_cnt;
  logic [1:0]  word_cnt2;
  logic [31:0] m_addr, m_addr2;
  logic        m_we, m_we2;
  logic [7:0]  m_wdata, m_wdata2;
  logic [31:0] m_rd;
  logic        tb_clr;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imem_load_arbiter #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .f_req_i(f_req), .f_addr_i(f_addr),
    .f_rdata_o(f_rdata), .f_valid_o(f_valid), .f_stall_o(f_stall),
    .l_valid_i(l_valid), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
    .l_ready_o(l_ready), .l_done_o(l_done), .word_cnt_o(word_cnt),
    .m_addr_o(m_addr), .m_we_o(m_we), .m_wdata_o(m_wdata), .m_rd_i(m_rd)
  );

  imem_load_arbiter #(.BYTE_SIZE(4), .ADDR_WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n), .f_req_i(f_req), .f_addr_i(f_addr),
    .f_rdata_o(f_rdata2), .f_valid_o(f_valid2), .f_stall_o(f_stall2),
    .l_valid_i(l_valid), .l_addr_i(l_addr), .l_wdata_i(l_wdata),
    .l_ready_o(l_ready2), .l_done_o(l_done2), .word_cnt_o(word_cnt2),
    .m_addr_o(m_addr2), .m_we_o(m_we2), .m_wdata_o(m_wdata2), .m_rd_i(32'h0)
  );

  // 256-byte memory model aliased on the low address byte
  logic [7:0] mem [256];
  logic [7:0] ra;
  assign ra   = m_addr[7:0];
  assign m_rd = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (m_we) begin
      mem[m_addr[7:0]] <= m_wdata;
    end
  end

  typedef struct {
    logic        fq;
    logic [31:0] fa;
    logic        lv;
    logic [31:0] la;
    logic [31:0] lw;
    logic        e_lrdy;
    logic        e_fvld;
    logic        e_fstall;
    logic        e_we;
    logic        e_done;
    logic [31:0] e_maddr;
    logic [7:0]  e_wdata;
    logic [31:0] e_rdata;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t v(input logic fq, input logic [31:0] fa, input logic lv,
                             input logic [31:0] la, input logic [31:0] lw,
                             input logic lrdy, input logic fvld, input logic fstall,
                             input logic we, input logic done, input logic [31:0] maddr,
                             input logic [7:0] wd, input logic [31:0] rdata,
                             input logic [15:0] cnt);
    vec_t r;
    r.fq = fq; r.fa = fa; r.lv = lv; r.la = la; r.lw = lw;
    r.e_lrdy = lrdy; r.e_fvld = fvld; r.e_fstall = fstall; r.e_we = we; r.e_done = done;
    r.e_maddr = maddr; r.e_wdata = wd; r.e_rdata = rdata; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fq, input logic [31:0] fa, input logic lv,
                       input logic [31:0] la, input logic [31:0] lw);
    f_req = fq; f_addr = fa; l_valid = lv; l_addr = la; l_wdata = lw;
  endtask

  vec_t tbl [21];
  int   ndone;

  initial begin
    rst_n = 1'b0;
    tb_clr = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    tbl[0]  = v(0, 32'h40, 1, 32'h10, 32'hE3A01005, 1, 0, 0, 0, 0, 32'h40, 8'h00, 32'h0, 16'd0);
    tbl[1]  = v(0, 32'h40, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h10, 8'h05, 32'h0, 16'd0);
    tbl[2]  = v(0, 32'h40, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h11, 8'h10, 32'h0, 16'd0);
    tbl[3]  = v(0, 32'h40, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h12, 8'hA0, 32'h0, 16'd0);
    tbl[4]  = v(0, 32'h40, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h13, 8'hE3, 32'h0, 16'd0);
    tbl[5]  = v(0, 32'h40, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 32'h0,  8'h00, 32'h0, 16'd1);
    tbl[6]  = v(1, 32'h10, 0, 32'h0,  32'h0,        1, 1, 0, 0, 0, 32'h10, 8'h00, 32'hE3A01005, 16'd1);
    tbl[7]  = v(1, 32'h12, 1, 32'h20, 32'h11223344, 1, 1, 0, 0, 0, 32'h12, 8'h00, 32'h0000E3A0, 16'd1);
    tbl[8]  = v(1, 32'h12, 0, 32'h0,  32'h0,        0, 0, 1, 1, 0, 32'h20, 8'h44, 32'h0, 16'd1);
    tbl[9]  = v(0, 32'h12, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h21, 8'h33, 32'h0, 16'd1);
    tbl[10] = v(0, 32'h12, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h22, 8'h22, 32'h0, 16'd1);
    tbl[11] = v(0, 32'h12, 0, 32'h0,  32'h0,        0, 0, 0, 1, 0, 32'h23, 8'h11, 32'h0, 16'd1);
    tbl[12] = v(0, 32'h12, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 32'h0,  8'h00, 32'h0, 16'd2);
    tbl[13] = v(1, 32'h20, 1, 32'h30, 32'hCAFEBABE, 0, 1, 0, 0, 0, 32'h20, 8'h00, 32'h11223344, 16'd2);
    tbl[14] = v(0, 32'h20, 1, 32'h30, 32'hCAFEBABE, 1, 0, 0, 0, 0, 32'h20, 8'h00, 32'h0, 16'd2);
    tbl[15] = v(0, 32'h20, 1, 32'h30, 32'hCAFEBABE, 0, 0, 0, 1, 0, 32'h30, 8'hBE, 32'h0, 16'd2);
    tbl[16] = v(0, 32'h20, 1, 32'h30, 32'hCAFEBABE, 0, 0, 0, 1, 0, 32'h31, 8'hBA, 32'h0, 16'd2);
    tbl[17] = v(0, 32'h20, 1, 32'h30, 32'hCAFEBABE, 0, 0, 0, 1, 0, 32'h32, 8'hFE, 32'h0, 16'd2);
    tbl[18] = v(0, 32'h20, 1, 32'h30, 32'hCAFEBABE, 0, 0, 0, 1, 0, 32'h33, 8'hCA, 32'h0, 16'd2);
    tbl[19] = v(0, 32'h20, 0, 32'h0,  32'h0,        0, 0, 0, 0, 1, 32'h0,  8'h00, 32'h0, 16'd3);
    tbl[20] = v(1, 32'h30, 0, 32'h0,  32'h0,        1, 1, 0, 0, 0, 32'h30, 8'h00, 32'hCAFEBABE, 16'd3);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_l_ready", l_ready, 1);
    chk("rst_m_we", m_we, 0);
    chk("rst_l_done", l_done, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_word_cnt_sat", word_cnt2, 0);
    tb_clr = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cyc();
      drive(tbl[i].fq, tbl[i].fa, tbl[i].lv, tbl[i].la, tbl[i].lw);
      #3;
      chk($sformatf("v%0d_l_ready", i), l_ready, tbl[i].e_lrdy);
      chk($sformatf("v%0d_f_valid", i), f_valid, tbl[i].e_fvld);
      chk($sformatf("v%0d_f_stall", i), f_stall, tbl[i].e_fstall);
      chk($sformatf("v%0d_m_we", i), m_we, tbl[i].e_we);
      chk($sformatf("v%0d_l_done", i), l_done, tbl[i].e_done);
      chk($sformatf("v%0d_word_cnt", i), word_cnt, tbl[i].e_cnt);
      if (tbl[i].e_we || tbl[i].e_fvld) chk($sformatf("v%0d_m_addr", i), m_addr, tbl[i].e_maddr);
      if (tbl[i].e_we) chk($sformatf("v%0d_m_wdata", i), m_wdata, tbl[i].e_wdata);
      if (tbl[i].e_fvld) chk($sformatf("v%0d_f_rdata", i), f_rdata, tbl[i].e_rdata);
    end

    // Contention: fetch always requesting, loader offering three words back to back
    ndone = 0;
    for (int c = 0; c < 21; c++) begin
      int k;
      int p;
      k = c / 7;
      p = c % 7;
      cyc();
      drive(1'b1, 32'h10, (c <= 14), 32'h80 + 32'(4 * k), 32'hA5A50000 + 32'(k));
      #3;
      chk($sformatf("cont%0d_f_stall", c), f_stall, (p >= 1 && p <= 5));
      chk($sformatf("cont%0d_f_valid", c), f_valid, (p == 0 || p == 6));
      chk($sformatf("cont%0d_l_ready", c), l_ready, (p == 0));
      chk($sformatf("cont%0d_m_we", c), m_we, (p >= 1 && p <= 4));
      chk($sformatf("cont%0d_l_done", c), l_done, (p == 5));
      if (l_done) ndone++;
    end
    chk("cont_done_pulses", ndone, 3);
    chk("cont_word_cnt", word_cnt, 6);

    // Address wrap past the top of the byte address space
    cyc();
    drive(1'b0, 32'h0, 1'b1, 32'hFFFFFFFE, 32'h44332211);
    #3;
    chk("wrap_accept", l_ready, 1);
    begin
      logic [31:0] wa [4];
      logic [7:0]  wb [4];
      wa[0] = 32'hFFFFFFFE; wa[1] = 32'hFFFFFFFF; wa[2] = 32'h0; wa[3] = 32'h1;
      wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
        cyc();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        #3;
        chk($sformatf("wrap%0d_m_we", i), m_we, 1);
        chk($sformatf("wrap%0d_m_addr", i), m_addr, wa[i]);
        chk($sformatf("wrap%0d_m_wdata", i), m_wdata, wb[i]);
      end
    end
    cyc();
    #3;
    chk("wrap_l_done", l_done, 1);
    chk("wrap_word_cnt", word_cnt, 7);

    // Asynchronous reset in the middle of a word write
    cyc();
    drive(1'b0, 32'h0, 1'b1, 32'h50, 32'hA1B2C3D4);
    #3;
    chk("rstw_accept", l_ready, 1);
    cyc();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    #3;
    chk("rstw_we0", m_we, 1);
    cyc();
    #3;
    chk("rstw_we1", m_we, 1);
    cyc();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_m_we", m_we, 0);
    chk("rstw_l_ready", l_ready, 1);
    chk("rstw_word_cnt", word_cnt, 0);
    chk("rstw_l_done", l_done, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    drive(1'b1, 32'h50, 1'b0, 32'h0, 32'h0);
    #3;
    chk("rstw_f_valid", f_valid, 1);
    chk("rstw_f_rdata", f_rdata, 32'h0000C3D4);

    // Saturating counter and back-to-back loader throughput with no fetch
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      int k;
      int p;
      k = c / 6;
      p = c % 6;
      cyc();
      drive(1'b0, 32'h0, (c <= 24), 32'h90 + 32'(4 * k), 32'h01010101 * 32'(k + 1));
      #3;
      chk($sformatf("sat%0d_l_ready", c), l_ready, (p == 0));
      chk($sformatf("sat%0d_l_done", c), l_done2, (p == 5));
      if (p == 5) begin
        chk($sformatf("sat%0d_cnt2", c), word_cnt2, (k + 1 > 3) ? 3 : k + 1);
        chk($sformatf("sat%0d_cnt16", c), word_cnt, k + 1);
      end
      if (l_done2) ndone++;
    end
    chk("sat_done_pulses", ndone, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
